// File: rtl/axi4_pkg.sv
// Shared AXI4 write-channel encodings, field widths and the latched AW request type.
package axi4_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_ID_W-1:0]   id;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi4w_aw_t;

endpackage

// File: rtl/axi4w_if.sv
// AXI4 write address, write data and write response channels with master/slave views.
interface axi4w_if;
    import axi4_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_ID_W-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [AXI_ID_W-1:0]   bid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bresp, bid
    );

endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
module axi4_burst_addr
    import axi4_pkg::*;
(
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [AXI_ADDR_W-1:0] next_addr
);

    logic [AXI_ADDR_W-1:0] step;
    logic [AXI_ADDR_W-1:0] incr;
    logic [AXI_ADDR_W-1:0] wrap_mask;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        step      = AXI_ADDR_W'(1) << size;
        incr      = addr + step;
        // The wrap window is the whole burst footprint: (len+1) beats of 2^size bytes.
        wrap_mask = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_INCR:  next_addr = incr;
            AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:         next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi4w_sram_slave.sv
// AXI4 write-channel slave driving a single-port SRAM write port, one burst at a time.
// Define AXI4W_SLV_STAT_EN to add the saturating err_cnt output counting error responses.
module axi4w_sram_slave
    import axi4_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                    MEM_WORDS = 4096,
    parameter int                    MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4w_if.slave                s,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [AXI_DATA_W-1:0] mem_wdata,
    output logic [AXI_STRB_W-1:0] mem_wstrb
`ifdef AXI4W_SLV_STAT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam int                WIN_W     = AXI_ADDR_W + 1;
    localparam logic [WIN_W-1:0]  WIN_BYTES = WIN_W'(MEM_WORDS) << 3;

    state_t                state;
    state_t                state_nxt;
    axi4w_aw_t             aw_q;
    logic [7:0]            beat_cnt;
    logic                  drain;
    logic                  slv_err;
    logic                  dec_err;
    logic                  setup_slv;
    logic                  setup_dec;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  last_beat;
    logic [AXI_ADDR_W-1:0] next_addr;
    logic [AXI_ADDR_W-1:0] offset;

    function automatic logic in_window(input logic [AXI_ADDR_W-1:0] a);
        logic [AXI_ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    endfunction

    axi4_burst_addr u_burst_addr (
        .addr      (aw_q.addr),
        .size      (aw_q.size),
        .len       (aw_q.len),
        .burst     (aw_q.burst),
        .next_addr (next_addr)
    );

    assign aw_hs     = s.awvalid && s.awready;
    assign w_hs      = s.wvalid && s.wready;
    assign b_hs      = s.bvalid && s.bready;
    assign last_beat = (beat_cnt == aw_q.len);
    assign offset    = aw_q.addr - BASE_ADDR;

    always_comb begin
        setup_slv = (s.awsize > 3'd3) || (s.awburst == 2'b11) ||
                    ((s.awburst == AXI_BURST_WRAP) &&
                     !(s.awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
        setup_dec = !in_window(s.awaddr);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs)             state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (b_hs)              state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state flops, so they change only at the edge.
    always_comb begin
        s.awready = (state == IDLE);
        s.wready  = (state == DATA);
        s.bvalid  = (state == RESP);
        s.bid     = aw_q.id;
        if (dec_err)      s.bresp = AXI_RESP_DECERR;
        else if (slv_err) s.bresp = AXI_RESP_SLVERR;
        else              s.bresp = AXI_RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_q      <= '0;
            beat_cnt  <= '0;
            drain     <= 1'b0;
            slv_err   <= 1'b0;
            dec_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            if (aw_hs) begin
                aw_q     <= '{addr: s.awaddr, id: s.awid, len: s.awlen,
                              size: s.awsize, burst: s.awburst};
                beat_cnt <= '0;
                drain    <= setup_slv || setup_dec;
                slv_err  <= setup_slv;
                dec_err  <= setup_dec;
            end else if (w_hs) begin
                aw_q.addr <= next_addr;
                beat_cnt  <= beat_cnt + 8'd1;
                // A wlast disagreement is only reported; the beat count alone ends the burst.
                if (s.wlast != last_beat) slv_err <= 1'b1;
                if (!drain) begin
                    if (in_window(aw_q.addr)) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= MEM_AW'(offset >> 3);
                        mem_wdata <= s.wdata;
                        mem_wstrb <= s.wstrb;
                    end else begin
                        dec_err <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef AXI4W_SLV_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (b_hs && (s.bresp != AXI_RESP_OKAY) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4w_sram_slave.sv
// Scoreboard bench for axi4w_sram_slave: expected SRAM writes are queued at each W handshake.
module tb_axi4w_sram_slave;
    import axi4_pkg::*;

    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          MEM_WORDS = 4096;
    localparam int          MEM_AW    = $clog2(MEM_WORDS);
    localparam int          BUDGET    = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wstrb;
`ifdef AXI4W_SLV_STAT_EN
    logic [15:0]       err_cnt;
    int                exp_err = 0;
`endif

    axi4w_if bus();

    axi4w_sram_slave #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
`ifdef AXI4W_SLV_STAT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          word;
        logic [63:0] data;
        logic [7:0]  strb;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    int  exp_word[$];

    // Every write the DUT makes must match the oldest queued expectation, including its cycle.
    always @(posedge clk) begin : monitor
        wr_t e;
        #1;
        if (mem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: mem_addr=%h mem_wdata=%h, no write expected", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== MEM_AW'(e.word) || mem_wdata !== e.data ||
                    mem_wstrb !== e.strb || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h strb=%h cyc=%0d, want addr=%h data=%h strb=%h cyc=%0d",
                             mem_addr, mem_wdata, mem_wstrb, cyc, MEM_AW'(e.word), e.data, e.strb, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awid    = id;
        n = 0;
        while (bus.awready !== 1'b1 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_timeout: awready=%b after %0d cycles, want 1", bus.awready, n);
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        checks++;
        if (bus.awready !== 1'b0 || bus.wready !== 1'b1) begin
            errors++;
            $display("FAIL aw_accept: awready=%b wready=%b, want 0 1", bus.awready, bus.wready);
        end
    endtask

    task automatic send_beat(input int word, input logic last);
        logic [63:0] d;
        logic [7:0]  st;
        int          n;
        d  = {$urandom, $urandom};
        st = 8'($urandom_range(0, 255));
        bus.wvalid = 1'b1;
        bus.wdata  = d;
        bus.wstrb  = st;
        bus.wlast  = last;
        n = 0;
        while (bus.wready !== 1'b1 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.wready !== 1'b1) begin
            errors++;
            $display("FAIL w_timeout: wready=%b after %0d cycles, want 1", bus.wready, n);
        end else if (word >= 0) begin
            sb.push_back('{word: word, data: d, strb: st, cyc: cyc + 1});
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic finish_b(input logic [1:0] exp_resp, input logic [3:0] id, input int delay);
        checks++;
        if (bus.bvalid !== 1'b1 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL last_beat_to_resp: bvalid=%b wready=%b, want 1 0", bus.bvalid, bus.wready);
        end
        for (int k = 0; k < delay; k++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.bresp !== exp_resp || bus.bid !== id) begin
                errors++;
                $display("FAIL b_hold: bvalid=%b awready=%b bresp=%b bid=%h, want 1 0 %b %h",
                         bus.bvalid, bus.awready, bus.bresp, bus.bid, exp_resp, id);
            end
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp || bus.bid !== id) begin
            errors++;
            $display("FAIL b_resp: bvalid=%b bresp=%b bid=%h, want 1 %b %h", bus.bvalid, bus.bresp, bus.bid, exp_resp, id);
        end
        @(posedge clk); #1;
        bus.bready = 1'b0;
        checks++;
        if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_to_idle: awready=%b bvalid=%b, want 1 0", bus.awready, bus.bvalid);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d expected writes never seen, want 0", sb.size());
            sb.delete();
        end
`ifdef AXI4W_SLV_STAT_EN
        if (exp_resp != AXI_RESP_OKAY) exp_err++;
`endif
    endtask

    // early_last < 0 means wlast rides on the final beat; otherwise only on that beat index.
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int early_last,
                            input logic [1:0] exp_resp, input int delay);
        send_aw(addr, len, size, burst, id);
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send_beat((i < exp_word.size()) ? exp_word[i] : -1,
                      (early_last >= 0) ? (i == early_last) : (i == int'(len)));
        end
        finish_b(exp_resp, id, delay);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: awready=%b wready=%b bvalid=%b, want 1 0 0", bus.awready, bus.wready, bus.bvalid);
        end
        checks++;
        if (bus.bresp !== 2'b00 || bus.bid !== 4'h0) begin
            errors++;
            $display("FAIL reset_b: bresp=%b bid=%h, want 00 0", bus.bresp, bus.bid);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin
            errors++;
            $display("FAIL reset_mem: we=%b addr=%h data=%h strb=%h, want all 0", mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
`ifdef AXI4W_SLV_STAT_EN
        checks++;
        if (err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_err_cnt: err_cnt=%h, want 0", err_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_idle_w;
        bus.wvalid = 1'b1;
        bus.wdata  = 64'hDEAD_BEEF_0000_0001;
        bus.wstrb  = 8'hFF;
        bus.wlast  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin
                errors++;
                $display("FAIL idle_w_ignored: wready=%b awready=%b, want 0 1", bus.wready, bus.awready);
            end
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic test_incr;
        exp_word = '{32'h20, 32'h21, 32'h22, 32'h23};
        do_burst(32'h100, 8'd3, 3'd3, AXI_BURST_INCR, 4'd5, -1, AXI_RESP_OKAY, 0);
    endtask

    task automatic test_wrap;
        exp_word = '{32'h23, 32'h20, 32'h21, 32'h22};
        do_burst(32'h118, 8'd3, 3'd3, AXI_BURST_WRAP, 4'd6, -1, AXI_RESP_OKAY, 1);
        exp_word = '{32'h21, 32'h20};
        do_burst(32'h108, 8'd1, 3'd3, AXI_BURST_WRAP, 4'd7, -1, AXI_RESP_OKAY, 0);
        exp_word = '{-1, -1, -1};
        do_burst(32'h118, 8'd2, 3'd3, AXI_BURST_WRAP, 4'd8, -1, AXI_RESP_SLVERR, 0);
    endtask

    task automatic test_fixed_narrow;
        exp_word = '{32'h08, 32'h08, 32'h08};
        do_burst(32'h40, 8'd2, 3'd3, AXI_BURST_FIXED, 4'd1, -1, AXI_RESP_OKAY, 0);
        exp_word = '{32'h08, 32'h09};
        do_burst(32'h44, 8'd1, 3'd2, AXI_BURST_INCR, 4'd2, -1, AXI_RESP_OKAY, 0);
    endtask

    task automatic test_window;
        exp_word = '{-1, -1};
        do_burst(BASE_ADDR + MEM_WORDS * 8, 8'd1, 3'd3, AXI_BURST_INCR, 4'hA, -1, AXI_RESP_DECERR, 0);
        exp_word = '{MEM_WORDS - 1, -1};
        do_burst(BASE_ADDR + (MEM_WORDS - 1) * 8, 8'd1, 3'd3, AXI_BURST_INCR, 4'hB, -1, AXI_RESP_DECERR, 0);
    endtask

    task automatic test_setup_errors;
        exp_word = '{-1};
        do_burst(32'h100, 8'd0, 3'd4, AXI_BURST_INCR, 4'hC, -1, AXI_RESP_SLVERR, 0);
        exp_word = '{-1, -1};
        do_burst(32'h100, 8'd1, 3'd3, 2'b11, 4'hD, -1, AXI_RESP_SLVERR, 0);
        exp_word = '{-1, -1};
        do_burst(32'h9000, 8'd1, 3'd3, 2'b11, 4'hE, -1, AXI_RESP_DECERR, 0);
    endtask

    task automatic test_wlast_bready;
        exp_word = '{32'h30, 32'h31, 32'h32, 32'h33};
        do_burst(32'h180, 8'd3, 3'd3, AXI_BURST_INCR, 4'h4, 1, AXI_RESP_SLVERR, 5);
    endtask

    task automatic test_stat;
`ifdef AXI4W_SLV_STAT_EN
        checks++;
        if (err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL err_cnt: err_cnt=%0d, want %0d", err_cnt, exp_err);
        end
`endif
    endtask

    task automatic test_reset_mid_burst;
        send_aw(32'h200, 8'd7, 3'd3, AXI_BURST_INCR, 4'h3);
        send_beat(32'h40, 1'b0);
        send_beat(32'h41, 1'b0);
        bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        checks++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_burst_reset: awready=%b wready=%b bvalid=%b mem_we=%b, want 1 0 0 0",
                     bus.awready, bus.wready, bus.bvalid, mem_we);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL partial_writes: %0d expected writes never seen, want 0", sb.size());
            sb.delete();
        end
`ifdef AXI4W_SLV_STAT_EN
        exp_err = 0;
`endif
        test_stat();
        exp_word = '{32'h60, 32'h61};
        do_burst(32'h300, 8'd1, 3'd3, AXI_BURST_INCR, 4'h9, -1, AXI_RESP_OKAY, 0);
        test_stat();
    endtask

    initial begin
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.awid    = '0;
        bus.awlen   = '0;
        bus.awsize  = '0;
        bus.awburst = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wlast   = 1'b0;
        bus.bready  = 1'b0;

        test_reset();
        test_idle_w();
        test_incr();
        test_wrap();
        test_fixed_narrow();
        test_window();
        test_setup_errors();
        test_wlast_bready();
        test_stat();
        test_reset_mid_burst();

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
